// File: rtl/cpu_sram_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM port seen by cpu_sram_arbiter.
// The arbiter uses the slave view; the CPU/SRAM side uses the master view.
interface cpu_sram_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_cancel;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr, inst_cancel,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output inst_req, inst_addr, inst_cancel,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Merges CPU fetch and data streams onto one synchronous SRAM port; a tag pipeline
// matching the SRAM read latency steers each response back to its issuer.
module cpu_sram_arbiter #(
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned MAX_DATA_BURST = 4
) (
   input logic              clk,
   input logic              reset,
   cpu_sram_arbiter_if.slave bus
);

   localparam logic [3:0] MaxBurst = 4'(MAX_DATA_BURST);
   localparam logic       SrcInst  = 1'b0;
   localparam logic       SrcData  = 1'b1;

   typedef struct packed {
      logic valid;
      logic src;
      logic kill;
      logic wr;
   } tag_t;

   tag_t [READ_LATENCY-1:0] tag_q, tag_d;
   tag_t                    head;
   logic [3:0]              burst_q, burst_d;
   logic                    inst_grant, data_grant;
   logic                    unused_addr_lsbs;

   // Byte offsets never reach the SRAM, which is word addressed.
   assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

   always_comb begin
      inst_grant = 1'b0;
      data_grant = 1'b0;
      if (!reset) begin
         if (bus.inst_req && (!bus.data_req || burst_q == MaxBurst)) begin
            inst_grant = 1'b1;
         end else if (bus.data_req) begin
            data_grant = 1'b1;
         end
      end
   end

   always_comb begin
      bus.inst_addr_ok = inst_grant;
      bus.data_addr_ok = data_grant;
      bus.mem_en       = inst_grant | data_grant;
      bus.mem_wen      = (data_grant && bus.data_wr) ? bus.data_wstrb : 4'b0000;
      bus.mem_wdata    = data_grant ? bus.data_wdata : 32'h0;
      bus.mem_addr     = 32'h0;
      if (inst_grant) begin
         bus.mem_addr = {bus.inst_addr[31:2], 2'b00};
      end else if (data_grant) begin
         bus.mem_addr = {bus.data_addr[31:2], 2'b00};
      end
   end

   always_comb begin
      burst_d = burst_q;
      if (!bus.inst_req || inst_grant) begin
         burst_d = 4'd0;
      end else if (data_grant && burst_q != MaxBurst) begin
         burst_d = burst_q + 4'd1;
      end
   end

   always_comb begin
      tag_d          = tag_q;
      tag_d[0].valid = inst_grant | data_grant;
      tag_d[0].src   = data_grant ? SrcData : SrcInst;
      tag_d[0].kill  = 1'b0;
      tag_d[0].wr    = data_grant & bus.data_wr;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         tag_d[i] = tag_q[i-1];
      end
      // A flush also catches the fetch being granted in the same cycle.
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
         if (bus.inst_cancel && tag_d[i].valid && tag_d[i].src == SrcInst) begin
            tag_d[i].kill = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q   <= '0;
         burst_q <= 4'd0;
      end else begin
         tag_q   <= tag_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      head             = tag_q[READ_LATENCY-1];
      bus.inst_data_ok = !reset && head.valid && head.src == SrcInst && !head.kill;
      bus.data_data_ok = !reset && head.valid && head.src == SrcData;
      bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : 32'h0;
      bus.data_rdata   = (bus.data_data_ok && !head.wr) ? bus.mem_rdata : 32'h0;
   end

endmodule
